// File: rtl/game_timer.sv
// Two-digit BCD countdown timer for the bomb game: load/arm/run/pause/defuse control,
// per-second decrement, expiry strobes. Optional low-time warning with GAME_TIMER_WARN_EN.
module game_timer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRE_W         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] tens_in,
  input  logic [3:0] ones_in,
  input  logic       start,
  input  logic       pause,
  input  logic       defuse,
  output logic [3:0] tens_out,
  output logic [3:0] ones_out,
  output logic       running,
  output logic       expired,
  output logic       expire_pulse,
  output logic       sec_pulse,
  output logic       warn
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  logic [2:0]       r_state;
  logic [PRE_W-1:0] r_pre;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;
  logic             r_running;
  logic             r_expired;
  logic             r_expire_pulse;
  logic             r_sec_pulse;

  logic [2:0]       w_state_nxt;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [3:0]       w_tens_nxt;
  logic [3:0]       w_ones_nxt;
  logic             w_sec_nxt;
  logic             w_expire_nxt;
  logic [3:0]       w_tens_clamp;
  logic [3:0]       w_ones_clamp;
  logic [3:0]       w_dec_tens;
  logic [3:0]       w_dec_ones;
  logic             w_dec_zero;
  logic             w_wrap;
  logic             w_is_zero;
  logic             w_pause_req;
  logic             w_resume_req;

  assign w_tens_clamp = (tens_in > 4'd9) ? 4'd9 : tens_in;
  assign w_ones_clamp = (ones_in > 4'd9) ? 4'd9 : ones_in;

  // BCD borrow: ones underflows to 9 and takes one from tens.
  assign w_dec_ones = (r_ones != 4'd0) ? (r_ones - 4'd1) : 4'd9;
  assign w_dec_tens = (r_ones != 4'd0) ? r_tens : (r_tens - 4'd1);
  assign w_dec_zero = (w_dec_tens == 4'd0) && (w_dec_ones == 4'd0);

  assign w_wrap       = (r_state == S_RUN) && (r_pre == PRE_LAST);
  assign w_is_zero    = (r_tens == 4'd0) && (r_ones == 4'd0);
  // Simultaneous pause and start cancel each other out.
  assign w_pause_req  = pause && !start;
  assign w_resume_req = start && !pause;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt  = r_state;
    w_pre_nxt    = r_pre;
    w_tens_nxt   = r_tens;
    w_ones_nxt   = r_ones;
    w_sec_nxt    = 1'b0;
    w_expire_nxt = 1'b0;

    case (r_state)
      S_IDLE, S_DONE, S_HALT: begin
        if (load) begin
          w_tens_nxt  = w_tens_clamp;
          w_ones_nxt  = w_ones_clamp;
          w_pre_nxt   = '0;
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (load) begin
          w_tens_nxt  = w_tens_clamp;
          w_ones_nxt  = w_ones_clamp;
          w_pre_nxt   = '0;
        end else if (start) begin
          if (w_is_zero) begin
            w_state_nxt  = S_DONE;
            w_expire_nxt = 1'b1;
          end else begin
            w_state_nxt  = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Defuse wins over everything, including a final decrement on the same edge.
        if (defuse) begin
          w_state_nxt = S_HALT;
        end else begin
          w_pre_nxt = w_wrap ? '0 : (r_pre + 1'b1);
          if (w_wrap) begin
            w_tens_nxt = w_dec_tens;
            w_ones_nxt = w_dec_ones;
            w_sec_nxt  = 1'b1;
          end
          if (w_wrap && w_dec_zero) begin
            w_state_nxt  = S_DONE;
            w_expire_nxt = 1'b1;
          end else if (w_pause_req) begin
            w_state_nxt  = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        if (defuse) begin
          w_state_nxt = S_HALT;
        end else if (w_resume_req) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with the digits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_pre          <= '0;
      r_tens         <= 4'd0;
      r_ones         <= 4'd0;
      r_running      <= 1'b0;
      r_expired      <= 1'b0;
      r_expire_pulse <= 1'b0;
      r_sec_pulse    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state        <= w_state_nxt;
      r_pre          <= w_pre_nxt;
      r_tens         <= w_tens_nxt;
      r_ones         <= w_ones_nxt;
      r_running      <= (w_state_nxt == S_RUN);
      r_expired      <= (w_state_nxt == S_DONE);
      r_expire_pulse <= w_expire_nxt;
      r_sec_pulse    <= w_sec_nxt;
    end
  end

  assign tens_out     = r_tens;
  assign ones_out     = r_ones;
  assign running      = r_running;
  assign expired      = r_expired;
  assign expire_pulse = r_expire_pulse;
  assign sec_pulse    = r_sec_pulse;

`ifdef GAME_TIMER_WARN_EN
  logic r_warn;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_warn <= 1'b0;
    end else begin
      r_warn <= ((w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE)) &&
                (w_tens_nxt == 4'd0) && (w_ones_nxt != 4'd0);
    end
  end

  assign warn = r_warn;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 SHALL have parameter: TICKS_PER_SEC, 50000000, clk cycles per game second (min 2).
REQ-002 SHALL have parameter: PRE_W, 26, prescaler width (2^PRE_W >= TICKS_PER_SEC).
REQ-003 SHALL have port: clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port: load  in  1  capture tens_in/ones_in as the countdown start value.
REQ-006 SHALL have port: tens_in  in  4  BCD tens digit of start value (from the level controller).
REQ-007 SHALL have port: ones_in  in  4  BCD ones digit of start value.
REQ-008 SHALL have port: start  in  1  begin or resume the countdown.
REQ-009 SHALL have port: pause  in  1  suspend the countdown.
REQ-010 SHALL have port: defuse  in  1  stop the countdown permanently (bomb defused).
REQ-011 SHALL have port: tens_out  out  4  current BCD tens digit.
REQ-012 SHALL have port: ones_out  out  4  current BCD ones digit.
REQ-013 SHALL have port: running  out  1  high while in RUN.
REQ-014 SHALL have port: expired  out  1  high while in DONE.
REQ-015 SHALL have port: expire_pulse  out  1  one-cycle strobe on entering DONE.
REQ-016 SHALL have port: sec_pulse  out  1  one-cycle strobe per decrement.
REQ-017 SHALL have port: warn  out  1  low-time warning (see Configuration).

Function
REQ-018 SHALL implement states IDLE, ARMED, RUN, PAUSE, DONE, HALT; all outputs registered.
REQ-019 SHALL, on load in IDLE/ARMED/DONE/HALT, capture the digits (any digit >9 clamped to 9), clear the prescaler, and go to ARMED next cycle; load SHALL be ignored in RUN/PAUSE.
REQ-020 SHALL go ARMED->RUN on start; if the captured value is 00, it SHALL go ARMED->DONE instead, with expire_pulse asserted in the cycle after.
REQ-021 SHALL increment the prescaler only in RUN, hold it in PAUSE, and wrap it to 0 on reaching TICKS_PER_SEC-1.
REQ-022 SHALL, on the wrap edge, decrement the value: ones>0 -> ones-1; ones=0 -> ones=9, tens-1. sec_pulse SHALL be high in the cycle the new value is visible.
REQ-023 SHALL, when a decrement yields 00, enter DONE on that same edge: expired=1; expire_pulse and sec_pulse both high for exactly that one cycle; digits hold 00.
REQ-024 SHALL go RUN->PAUSE on pause and PAUSE->RUN on start; pause and start together SHALL leave the state unchanged.
REQ-025 SHALL, if a wrap coincides with pause, apply the decrement and then enter PAUSE.
REQ-026 SHALL go RUN/PAUSE->HALT on defuse, freezing the digits; defuse SHALL beat a simultaneous final decrement (no expire, digits 01).
REQ-027 SHALL ignore start, pause and defuse in DONE and HALT; only load or reset leaves them.

Reset
REQ-028 SHALL, when rst=0 at a clock edge, force state IDLE, prescaler 0, and tens_out, ones_out, running, expired, expire_pulse, sec_pulse, warn all to 0; this applies from any state, including mid-countdown.

Configuration
REQ-029 SHALL, with GAME_TIMER_WARN_EN defined, drive warn=1 in RUN/PAUSE whenever tens_out=0 and ones_out!=0, registered alongside the digits.
REQ-030 SHALL, without GAME_TIMER_WARN_EN, tie warn to 0 and include no warn logic.

Verification (TICKS_PER_SEC=4)
REQ-031 SHALL check: load 1/2 then start -> sec_pulse every 4 cycles, digits 11,10,09 (ones wraps 0->9, tens decrements).
REQ-032 SHALL check: load 0/2 then start -> after 8 cycles digits 00, expired=1, expire_pulse and sec_pulse high for the same single cycle.
REQ-033 SHALL check: pause for 10 cycles mid-second, then start -> digits frozen while paused; the next decrement lands after exactly the remaining prescaler count.
REQ-034 SHALL check: defuse on the same edge as the 01->00 wrap -> HALT, digits 01, no expire_pulse; later start ignored.
REQ-035 SHALL check: load 0xC/0xF -> clamps to 99; load asserted during RUN -> ignored.
REQ-036 SHALL check: rst=0 mid-RUN -> all outputs 0 next cycle; with GAME_TIMER_WARN_EN, warn=1 at 09 and 0 at 00.
